// File: rtl/hamming_secded_codec.sv
// Pipelined Hamming SECDED encoder/decoder with a one-deep registered output stage,
// valid/ready handshakes and saturating single/double error counters.
module hamming_secded_codec #(
  parameter int unsigned N     = 7,
  parameter int unsigned R     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [1:N]       data_in,
  input  logic [1:N+R+1]   code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:N]       data_out,
  output logic [1:N+R+1]   code_out,
  output logic [R-1:0]     syndrome,
  output logic             err_single,
  output logic             err_double,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] double_cnt,
  input  logic             cnt_clr
);
  localparam int unsigned L = N + R + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  if ((1 << R) < L) begin : g_param_check
    $fatal(1, "hamming_secded_codec: 2^R must be >= N+R+1");
  end

  // Codeword position carrying data bit j; data_in[N] takes the highest non-power-of-two slot.
  function automatic int data_pos(int j);
    int k;
    data_pos = 0;
    k = N;
    for (int p = N + R; p >= 1; p--) begin
      if ((p & (p - 1)) != 0) begin
        if (k == j) data_pos = p;
        k--;
      end
    end
  endfunction

  logic [1:L]       enc_code;
  logic [R-1:0]     dec_syn;
  logic             dec_par;
  logic             dec_single;
  logic             dec_double;
  logic [1:L]       dec_code;
  logic [1:N]       dec_data;
  logic             xfer;

  logic             valid_q;
  logic [1:N]       data_q;
  logic [1:L]       code_q;
  logic [R-1:0]     syn_q;
  logic             single_q;
  logic             double_q;
  logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
  logic [CNT_W-1:0] double_cnt_q, double_cnt_d;

  always_comb begin
    enc_code = '0;
    for (int j = 1; j <= N; j++) enc_code[data_pos(j)] = data_in[j];
    for (int i = 0; i < R; i++) begin
      for (int p = 1; p <= N + R; p++) begin
        if (p[i] && (p != (1 << i))) enc_code[1 << i] ^= enc_code[p];
      end
    end
    enc_code[L] = ^enc_code[1:N+R];
  end

  always_comb begin
    dec_syn = '0;
    for (int i = 0; i < R; i++) begin
      for (int p = 1; p <= N + R; p++) begin
        if (p[i]) dec_syn[i] ^= code_in[p];
      end
    end
    dec_par    = ^code_in;
    // Odd overall parity with a syndrome pointing inside the word is a correctable single error.
    dec_single = dec_par && (32'(dec_syn) <= N + R);
    dec_double = (dec_syn != '0) && !dec_single;

    dec_code = code_in;
    if (dec_single) begin
      if (dec_syn == '0) begin
        dec_code[L] = ~code_in[L];
      end else begin
        for (int p = 1; p <= N + R; p++) begin
          if (dec_syn == R'(p)) dec_code[p] = ~code_in[p];
        end
      end
    end
    dec_data = '0;
    for (int j = 1; j <= N; j++) dec_data[j] = dec_code[data_pos(j)];
  end

  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    if (cnt_clr) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end else if (xfer && mode) begin
      if (dec_single && single_cnt_q != CntMax) single_cnt_d = single_cnt_q + CNT_W'(1);
      if (dec_double && double_cnt_q != CntMax) double_cnt_d = double_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      code_q       <= '0;
      syn_q        <= '0;
      single_q     <= 1'b0;
      double_q     <= 1'b0;
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      if (xfer) begin
        valid_q  <= 1'b1;
        data_q   <= mode ? dec_data : data_in;
        code_q   <= mode ? dec_code : enc_code;
        syn_q    <= mode ? dec_syn : '0;
        single_q <= mode && dec_single;
        double_q <= mode && dec_double;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign data_out   = data_q;
  assign code_out   = code_q;
  assign syndrome   = syn_q;
  assign err_single = single_q;
  assign err_double = double_q;
  assign single_cnt = single_cnt_q;
  assign double_cnt = double_cnt_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Bench for hamming_secded_codec: two instances (N=4/R=3/CNT_W=2 and the defaults) checked
// every cycle against a position-arithmetic model, plus hand-computed literal vectors.
module tb_hamming_secded_codec;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, mode, out_ready, cnt_clr;
  logic [15:0] i_data [2];
  logic [15:0] i_code [2];

  logic       a_in_ready, a_out_valid, a_es, a_ed;
  logic [1:4] a_data_out;
  logic [1:8] a_code_out;
  logic [2:0] a_syn;
  logic [1:0] a_sc, a_dc;

  logic        b_in_ready, b_out_valid, b_es, b_ed;
  logic [1:7]  b_data_out;
  logic [1:12] b_code_out;
  logic [3:0]  b_syn;
  logic [15:0] b_sc, b_dc;

  hamming_secded_codec #(.N(4), .R(3), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .mode(mode),
    .data_in(i_data[0][3:0]), .code_in(i_code[0][7:0]), .out_valid(a_out_valid),
    .out_ready(out_ready), .data_out(a_data_out), .code_out(a_code_out), .syndrome(a_syn),
    .err_single(a_es), .err_double(a_ed), .single_cnt(a_sc), .double_cnt(a_dc),
    .cnt_clr(cnt_clr)
  );

  hamming_secded_codec dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .mode(mode),
    .data_in(i_data[1][6:0]), .code_in(i_code[1][11:0]), .out_valid(b_out_valid),
    .out_ready(out_ready), .data_out(b_data_out), .code_out(b_code_out), .syndrome(b_syn),
    .err_single(b_es), .err_double(b_ed), .single_cnt(b_sc), .double_cnt(b_dc),
    .cnt_clr(cnt_clr)
  );

  logic [15:0] o_data [2];
  logic [15:0] o_code [2];
  logic [15:0] o_sc [2];
  logic [15:0] o_dc [2];
  logic [3:0]  o_syn [2];
  logic        o_valid [2];
  logic        o_ready [2];
  logic        o_es [2];
  logic        o_ed [2];

  assign o_data[0] = {12'b0, a_data_out};
  assign o_code[0] = {8'b0, a_code_out};
  assign o_sc[0] = {14'b0, a_sc};
  assign o_dc[0] = {14'b0, a_dc};
  assign o_syn[0] = {1'b0, a_syn};
  assign o_valid[0] = a_out_valid;
  assign o_ready[0] = a_in_ready;
  assign o_es[0] = a_es;
  assign o_ed[0] = a_ed;
  assign o_data[1] = {9'b0, b_data_out};
  assign o_code[1] = {4'b0, b_code_out};
  assign o_sc[1] = b_sc;
  assign o_dc[1] = b_dc;
  assign o_syn[1] = b_syn;
  assign o_valid[1] = b_out_valid;
  assign o_ready[1] = b_in_ready;
  assign o_es[1] = b_es;
  assign o_ed[1] = b_ed;

  localparam int NN [2] = '{4, 7};
  localparam int RR [2] = '{3, 4};
  localparam int CW [2] = '{2, 16};

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Words are right-aligned: codeword position p sits at bit (n+r+1-p), data_in[j] at bit (n-j).
  function automatic logic [15:0] encode(int n, int r, logic [15:0] d);
    int l;
    int j;
    int s;
    logic [15:0] c;
    l = n + r + 1;
    j = n;
    s = 0;
    c = '0;
    for (int p = n + r; p >= 1; p--) begin
      if ((p & (p - 1)) != 0) begin
        if (d[n - j]) begin
          c[l - p] = 1'b1;
          s = s ^ p;
        end
        j--;
      end
    end
    // Parity bits chosen so the XOR of all set positions becomes zero.
    for (int i = 0; i < r; i++) if (s[i]) c[l - (1 << i)] = 1'b1;
    c[0] = ^c;
    return c;
  endfunction

  typedef struct {
    logic [15:0] data;
    logic [15:0] code;
    logic [3:0]  syn;
    logic        es;
    logic        ed;
  } res_t;

  function automatic res_t model(int n, int r, logic md, logic [15:0] d, logic [15:0] c);
    res_t o;
    int l;
    int s;
    int j;
    logic par;
    logic [15:0] corr;
    l = n + r + 1;
    s = 0;
    o.data = '0;
    o.code = '0;
    o.syn = '0;
    o.es = 1'b0;
    o.ed = 1'b0;
    if (!md) begin
      o.data = d & ((16'd1 << n) - 16'd1);
      o.code = encode(n, r, d);
      return o;
    end
    corr = c & ((16'd1 << l) - 16'd1);
    for (int p = 1; p <= n + r; p++) if (corr[l - p]) s = s ^ p;
    par = ^corr;
    if (par && s <= n + r) begin
      o.es = 1'b1;
      if (s == 0) corr[0] = ~corr[0];
      else corr[l - s] = ~corr[l - s];
    end else if (s != 0) begin
      o.ed = 1'b1;
    end
    o.syn = s[3:0];
    o.code = corr;
    j = n;
    for (int p = n + r; p >= 1; p--) begin
      if ((p & (p - 1)) != 0) begin
        o.data[n - j] = corr[l - p];
        j--;
      end
    end
    return o;
  endfunction

  function automatic logic [15:0] rnd_code(int n, int r, int flips);
    logic [15:0] c;
    int b;
    c = encode(n, r, 16'($urandom));
    for (int f = 0; f < flips; f++) begin
      b = $urandom_range(n + r, 0);
      c[b] = ~c[b];
    end
    return c;
  endfunction

  function automatic logic [15:0] rnd_b;
    return 16'($urandom_range(127, 0));
  endfunction

  typedef struct {
    logic v;
    res_t r;
    int   sc;
    int   dc;
  } st_t;
  st_t m [2];

  initial begin : compare
    res_t  nr;
    logic  rdy;
    string pfx;
    for (int k = 0; k < 2; k++) begin
      m[k].v = 1'b0;
      m[k].sc = 0;
      m[k].dc = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        pfx = (k == 0) ? "a." : "b.";
        if (!rst_n) begin
          chk({pfx, "rst_valid"}, o_valid[k], 0);
          chk({pfx, "rst_ready"}, o_ready[k], 1);
          chk({pfx, "rst_data"}, o_data[k], 0);
          chk({pfx, "rst_code"}, o_code[k], 0);
          chk({pfx, "rst_syn"}, o_syn[k], 0);
          chk({pfx, "rst_flags"}, {o_es[k], o_ed[k]}, 0);
          chk({pfx, "rst_cnts"}, {o_sc[k], o_dc[k]}, 0);
          m[k].v = 1'b0;
          m[k].sc = 0;
          m[k].dc = 0;
        end else begin
          chk({pfx, "in_ready"}, o_ready[k], !m[k].v || out_ready);
          chk({pfx, "out_valid"}, o_valid[k], m[k].v);
          if (m[k].v) begin
            chk({pfx, "data_out"}, o_data[k], m[k].r.data);
            chk({pfx, "code_out"}, o_code[k], m[k].r.code);
            chk({pfx, "syndrome"}, o_syn[k], m[k].r.syn);
            chk({pfx, "err_single"}, o_es[k], m[k].r.es);
            chk({pfx, "err_double"}, o_ed[k], m[k].r.ed);
          end
          chk({pfx, "single_cnt"}, o_sc[k], m[k].sc);
          chk({pfx, "double_cnt"}, o_dc[k], m[k].dc);
          rdy = !m[k].v || out_ready;
          if (in_valid && rdy) begin
            nr = model(NN[k], RR[k], mode, i_data[k], i_code[k]);
            m[k].v = 1'b1;
            m[k].r = nr;
            if (nr.es && m[k].sc < (1 << CW[k]) - 1) m[k].sc++;
            if (nr.ed && m[k].dc < (1 << CW[k]) - 1) m[k].dc++;
          end else if (out_ready) begin
            m[k].v = 1'b0;
          end
          if (cnt_clr) begin
            m[k].sc = 0;
            m[k].dc = 0;
          end
        end
      end
    end
  end

  task automatic send(logic md, logic [15:0] da, logic [15:0] ca, logic [15:0] db,
                      logic [15:0] cb);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    mode = md;
    i_data[0] = da;
    i_code[0] = ca;
    i_data[1] = db;
    i_code[1] = cb;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    res_t t;
    logic [15:0] ca, cb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    mode = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_data[k] = '0;
      i_code[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 1);
    rst_n = 1'b1;

    chk("model_enc", encode(4, 3, 16'b1011), 16'b01100110);
    t = model(4, 3, 1'b1, 16'd0, 16'b01101110);
    chk("model_syn", t.syn, 4'b0101);
    chk("model_fix", t.code, 16'b01100110);

    send(1'b0, 16'b1011, 16'd0, rnd_b(), 16'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("enc_valid", a_out_valid, 1);
    chk("enc_code", a_code_out, 8'b01100110);
    chk("enc_syn", a_syn, 3'b000);
    chk("enc_data", a_data_out, 4'b1011);
    step();

    send(1'b1, 16'd0, 16'b01101110, 16'd0, rnd_code(7, 4, 1));
    in_valid = 1'b0;
    @(negedge clk);
    chk("p5_syn", a_syn, 3'b101);
    chk("p5_single", a_es, 1);
    chk("p5_data", a_data_out, 4'b1011);
    chk("p5_code", a_code_out, 8'b01100110);
    chk("p5_cnt", a_sc, 2'd1);
    step();

    send(1'b1, 16'd0, 16'b10100110, 16'd0, rnd_code(7, 4, 2));
    in_valid = 1'b0;
    @(negedge clk);
    chk("p12_syn", a_syn, 3'b011);
    chk("p12_flags", {a_es, a_ed}, 2'b01);
    chk("p12_cnt", a_dc, 2'd1);
    step();

    send(1'b1, 16'd0, 16'b01100111, 16'd0, rnd_code(7, 4, 0));
    in_valid = 1'b0;
    @(negedge clk);
    chk("p8_syn", a_syn, 3'b000);
    chk("p8_single", a_es, 1);
    chk("p8_data", a_data_out, 4'b1011);
    chk("p8_code", a_code_out, 8'b01100110);
    step();

    out_ready = 1'b0;
    send(1'b0, 16'b0001, 16'd0, rnd_b(), 16'd0);
    i_data[0] = 16'b1011;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", a_in_ready, 0);
      chk("stall_hold", a_code_out, 8'b11010010);
      step();
    end
    out_ready = 1'b1;
    step();
    i_data[0] = 16'b0110;
    @(negedge clk);
    chk("b2b_first", a_code_out, 8'b01100110);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second", a_code_out, 8'b11001100);
    chk("b2b_valid", a_out_valid, 1);
    step();

    for (int i = 0; i < 24; i++) begin
      ca = rnd_code(4, 3, i % 3);
      cb = rnd_code(7, 4, i % 3);
      // Triple flips whose syndrome (12 or 13) points past the last codeword position.
      if (i % 6 == 5) cb = encode(7, 4, rnd_b()) ^ (((i / 6) % 2 == 1) ? 16'h0111 : 16'h0910);
      send((i % 4) != 0, 16'($urandom_range(15, 0)), ca, rnd_b(), cb);
    end
    in_valid = 1'b0;
    step();

    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    repeat (5) send(1'b1, 16'd0, 16'b01101110, 16'd0, rnd_code(7, 4, 1));
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_single", a_sc, 2'd3);
    step();
    cnt_clr = 1'b1;
    send(1'b1, 16'd0, 16'b01101110, 16'd0, rnd_code(7, 4, 1));
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", a_sc, 2'd0);
    chk("clr_flag", a_es, 1);
    step();

    out_ready = 1'b0;
    send(1'b1, 16'd0, 16'b10100110, 16'd0, rnd_code(7, 4, 2));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", a_out_valid, 0);
    chk("rst_async_ready", a_in_ready, 1);
    chk("rst_async_cnt", a_dc, 2'd0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("discarded", a_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
